program_counter: RTL and testbench

//  Architectural program counter of the single-cycle RISC-V core.

---
 rtl/program_counter_pkg.sv | 17 +
 rtl/program_counter_branch_resolve.sv | 27 ++
 rtl/program_counter.sv | 65 ++++++
 tb/tb_program_counter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/program_counter_pkg.sv
// Shared control constants: datapath width and jump/branch select encodings.
package program_counter_pkg;

    localparam int XLEN = 32;

    // Jump/branch select driven by decode; 3'd7 is reserved and behaves as NONE.
    typedef enum logic [2:0] {
        JMP_NONE = 3'd0,
        JMP_JAL  = 3'd1,
        JMP_JALR = 3'd2,
        JMP_BEQ  = 3'd3,
        JMP_BNE  = 3'd4,
        JMP_BLT  = 3'd5,
        JMP_BGT  = 3'd6
    } jmp_t;

endpackage

// File: rtl/program_counter_branch_resolve.sv
// Decides whether the current jump/branch redirects the PC, from the select code and ALU flags.
module program_counter_branch_resolve
    import program_counter_pkg::*;
(
    input  logic [2:0] i_branch_type,
    input  logic       i_alu_zero,
    input  logic       i_alu_neg,
    output logic       o_taken,
    output logic       o_is_jalr
);

    // Flags only matter for conditional branches; JAL is unconditional, JALR is flagged separately.
    always_comb begin
        o_taken   = 1'b0;
        o_is_jalr = 1'b0;
        case (i_branch_type)
            JMP_JAL:  o_taken   = 1'b1;
            JMP_JALR: o_is_jalr = 1'b1;
            JMP_BEQ:  o_taken   = i_alu_zero;
            JMP_BNE:  o_taken   = ~i_alu_zero;
            JMP_BLT:  o_taken   = i_alu_neg;
            JMP_BGT:  o_taken   = ~i_alu_neg & ~i_alu_zero;
            default:  o_taken   = 1'b0;
        endcase
    end

endmodule

// File: rtl/program_counter.sv
// Architectural program counter: next-PC selection, pc+4 / pc+offset adders and the pc register.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int              XLEN_P   = XLEN,
    parameter logic [XLEN_P-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [XLEN_P-1:0] pc_offset,
    input  logic [XLEN_P-1:0] target_pc,
    input  logic [2:0]        branch_type,
    input  logic              alu_zero,
    input  logic              alu_neg,
    input  logic              stay,
    output logic [XLEN_P-1:0] pc,
    output logic [XLEN_P-1:0] return_pc
);

    logic [XLEN_P-1:0] r_pc;
    logic [XLEN_P-1:0] w_pc_plus4;
    logic [XLEN_P-1:0] w_pc_plus_off;
    logic [XLEN_P-1:0] w_jalr_target;
    logic [XLEN_P-1:0] w_next_pc;
    logic              w_taken;
    logic              w_is_jalr;

    program_counter_branch_resolve u_branch_resolve (
        .i_branch_type (branch_type),
        .i_alu_zero    (alu_zero),
        .i_alu_neg     (alu_neg),
        .o_taken       (w_taken),
        .o_is_jalr     (w_is_jalr)
    );

    // Adders wrap modulo 2^XLEN; a negative offset simply moves the pc backwards.
    assign w_pc_plus4    = r_pc + XLEN_P'(4);
    assign w_pc_plus_off = r_pc + pc_offset;
    assign w_jalr_target = {target_pc[XLEN_P-1:1], 1'b0};

    // Next-PC priority: stall hold, then JALR, then taken JAL/branch, else sequential.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (stay) begin
            w_next_pc = r_pc;
        end else if (w_is_jalr) begin
            w_next_pc = w_jalr_target;
        end else if (w_taken) begin
            w_next_pc = w_pc_plus_off;
        end
    end

    // PC register; reset overrides stall and any pending branch.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    assign pc        = r_pc;
    assign return_pc = w_pc_plus4;

endmodule

// File: tb/tb_program_counter.sv
// Directed testbench for program_counter: each task drives one scenario and checks pc/return_pc.
module tb_program_counter;

    logic        clk;
    logic        rstn;
    logic [31:0] pc_offset;
    logic [31:0] target_pc;
    logic [2:0]  branch_type;
    logic        alu_zero;
    logic        alu_neg;
    logic        stay;
    logic [31:0] pc;
    logic [31:0] return_pc;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_pc;

    program_counter #(.XLEN_P(32), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .pc_offset   (pc_offset),
        .target_pc   (target_pc),
        .branch_type (branch_type),
        .alu_zero    (alu_zero),
        .alu_neg     (alu_neg),
        .stay        (stay),
        .pc          (pc),
        .return_pc   (return_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Move the pc to an even address with a JALR (stimulus only).
    task automatic set_pc(input logic [31:0] value);
        stay = 1'b0; branch_type = 3'd2; target_pc = value;
        step();
        branch_type = 3'd0;
    endtask

    task automatic test_reset();
        rstn = 1'b1; stay = 1'b1; branch_type = 3'd1; pc_offset = 32'd12;
        target_pc = 32'h0; alu_zero = 1'b0; alu_neg = 1'b0;
        step();
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: pc=%h expected %h", pc, 32'h0); end
        n_checks++; if (return_pc !== 32'h4) begin n_fail++; $display("FAIL reset_ret: return_pc=%h expected %h", return_pc, 32'h4); end
        $display("reset: pc=%h return_pc=%h", pc, return_pc);
        rstn = 1'b0; stay = 1'b0; branch_type = 3'd0;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            step();
            exp_pc = 32'(4 * i);
            n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL seq_pc[%0d]: pc=%h expected %h", i, pc, exp_pc); end
            n_checks++; if (return_pc !== exp_pc + 32'd4) begin n_fail++; $display("FAIL seq_ret[%0d]: return_pc=%h expected %h", i, return_pc, exp_pc + 32'd4); end
            $display("seq: pc=%h return_pc=%h", pc, return_pc);
        end
    endtask

    task automatic test_jal_beq();
        set_pc(32'd8);
        pc_offset = 32'd12; branch_type = 3'd1; alu_zero = 1'b0; alu_neg = 1'b1;
        step();
        n_checks++; if (pc !== 32'd20) begin n_fail++; $display("FAIL jal: pc=%h expected %h", pc, 32'd20); end
        $display("jal: pc=%h", pc);
        branch_type = 3'd3; alu_zero = 1'b1; alu_neg = 1'b0;
        step();
        n_checks++; if (pc !== 32'd32) begin n_fail++; $display("FAIL beq_taken: pc=%h expected %h", pc, 32'd32); end
        $display("beq taken: pc=%h", pc);
        alu_zero = 1'b0;
        step();
        n_checks++; if (pc !== 32'd36) begin n_fail++; $display("FAIL beq_not_taken: pc=%h expected %h", pc, 32'd36); end
        $display("beq not taken: pc=%h", pc);
    endtask

    // Table: branch_type, zero, neg, expected pc delta.
    task automatic test_conditional();
        logic [2:0] bt [10]  = '{3'd4, 3'd4, 3'd5, 3'd6, 3'd6, 3'd6, 3'd5, 3'd7, 3'd3, 3'd5};
        logic       z  [10]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       n  [10]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] d [10]  = '{32'd4, 32'd12, 32'd12, 32'd4, 32'd12, 32'd4, 32'd4, 32'd4, 32'd12, 32'd12};
        set_pc(32'h100);
        exp_pc = 32'h100;
        pc_offset = 32'd12;
        for (int i = 0; i < 10; i++) begin
            branch_type = bt[i]; alu_zero = z[i]; alu_neg = n[i];
            step();
            exp_pc = exp_pc + d[i];
            n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL cond[%0d] bt=%0d z=%b n=%b: pc=%h expected %h", i, bt[i], z[i], n[i], pc, exp_pc); end
            $display("cond[%0d] bt=%0d z=%b n=%b: pc=%h", i, bt[i], z[i], n[i], pc);
        end
        branch_type = 3'd0;
    endtask

    task automatic test_jalr();
        branch_type = 3'd2; target_pc = 32'hAD; pc_offset = 32'd12; alu_zero = 1'b0; alu_neg = 1'b0;
        step();
        n_checks++; if (pc !== 32'hAC) begin n_fail++; $display("FAIL jalr_odd: pc=%h expected %h", pc, 32'hAC); end
        n_checks++; if (return_pc !== 32'hB0) begin n_fail++; $display("FAIL jalr_ret: return_pc=%h expected %h", return_pc, 32'hB0); end
        $display("jalr odd: pc=%h return_pc=%h", pc, return_pc);
        target_pc = 32'hAC; alu_zero = 1'b1; alu_neg = 1'b1;
        step();
        n_checks++; if (pc !== 32'hAC) begin n_fail++; $display("FAIL jalr_even: pc=%h expected %h", pc, 32'hAC); end
        $display("jalr even: pc=%h", pc);
        branch_type = 3'd0; alu_zero = 1'b0; alu_neg = 1'b0;
    endtask

    task automatic test_stall();
        set_pc(32'h40);
        stay = 1'b1; branch_type = 3'd1; pc_offset = 32'd12;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL stall_pc[%0d]: pc=%h expected %h", i, pc, 32'h40); end
            n_checks++; if (return_pc !== 32'h44) begin n_fail++; $display("FAIL stall_ret[%0d]: return_pc=%h expected %h", i, return_pc, 32'h44); end
            $display("stall[%0d]: pc=%h return_pc=%h", i, pc, return_pc);
        end
        branch_type = 3'd2; target_pc = 32'h200;
        step();
        n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL stall_jalr: pc=%h expected %h", pc, 32'h40); end
        $display("stall jalr: pc=%h", pc);
        stay = 1'b0; branch_type = 3'd1;
        step();
        n_checks++; if (pc !== 32'h4C) begin n_fail++; $display("FAIL stall_resume: pc=%h expected %h", pc, 32'h4C); end
        $display("resume: pc=%h", pc);
        branch_type = 3'd0;
    endtask

    task automatic test_wrap();
        set_pc(32'hFFFF_FFFC);
        n_checks++; if (return_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_ret: return_pc=%h expected %h", return_pc, 32'h0); end
        step();
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_seq: pc=%h expected %h", pc, 32'h0); end
        $display("wrap: pc=%h", pc);
        set_pc(32'd16);
        branch_type = 3'd1; pc_offset = 32'hFFFF_FFF8;
        step();
        n_checks++; if (pc !== 32'd8) begin n_fail++; $display("FAIL neg_offset: pc=%h expected %h", pc, 32'd8); end
        $display("neg offset: pc=%h", pc);
        pc_offset = 32'd3;
        step();
        n_checks++; if (pc !== 32'd11) begin n_fail++; $display("FAIL misaligned: pc=%h expected %h", pc, 32'd11); end
        $display("misaligned: pc=%h", pc);
        branch_type = 3'd0;
    endtask

    task automatic test_reset_midrun();
        set_pc(32'h300);
        rstn = 1'b1; stay = 1'b1; branch_type = 3'd1; pc_offset = 32'd12;
        step();
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rst_mid_pc: pc=%h expected %h", pc, 32'h0); end
        n_checks++; if (return_pc !== 32'h4) begin n_fail++; $display("FAIL rst_mid_ret: return_pc=%h expected %h", return_pc, 32'h4); end
        $display("reset midrun: pc=%h return_pc=%h", pc, return_pc);
        stay = 1'b0; branch_type = 3'd2; target_pc = 32'h500;
        step();
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rst_jalr: pc=%h expected %h", pc, 32'h0); end
        $display("reset jalr: pc=%h", pc);
        rstn = 1'b0; branch_type = 3'd0;
        step();
        n_checks++; if (pc !== 32'h4) begin n_fail++; $display("FAIL rst_release: pc=%h expected %h", pc, 32'h4); end
        $display("release: pc=%h", pc);
    endtask

    initial begin
        rstn = 1'b1; stay = 1'b0; branch_type = 3'd0; pc_offset = '0;
        target_pc = '0; alu_zero = 1'b0; alu_neg = 1'b0;
        test_reset();
        test_sequential();
        test_jal_beq();
        test_conditional();
        test_jalr();
        test_stall();
        test_wrap();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
